ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state changes on posedge CLK.
REQ-002 Parameter BASE, 13'h1000, lowest RAM byte address.
REQ-003 Parameter DEPTH, 4096, RAM size in bytes; valid window is BASE..BASE+DEPTH-1.
REQ-004 CLK  input  1  system clock.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 A_REQ / B_REQ  input  1  access request, port A (CPU) / port B (DMA).
REQ-007 A_WE / B_WE  input  1  1 = write, 0 = read.
REQ-008 A_ADDR / B_ADDR  input  13  byte address.
REQ-009 A_WDATA / B_WDATA  input  8  write data.
REQ-010 A_RDATA / B_RDATA  output  8  read data, valid while ACK high.
REQ-011 A_ACK / B_ACK  output  1  one-cycle completion pulse.
REQ-012 A_ERR / B_ERR  output  1  address out of window, valid with ACK.
REQ-013 DATA  inout  8  RAM data bus.
REQ-014 ADDRESS  output  13  RAM address.
REQ-015 ENABLE / MEM_RD / MEM_WR  output  1  RAM select and edge-sensitive read/write strobes.

Function
REQ-016 States SHALL be IDLE, SETUP, STROBE, HOLD, DONE.
REQ-017 In IDLE with any REQ high, the arbiter SHALL grant one port, latch its WE/ADDR/WDATA, and go to SETUP (valid address) or DONE with ERR set (out of window).
REQ-018 Both REQ high in IDLE: grant the port not granted last (round-robin); single request: grant it.
REQ-019 SETUP: ENABLE=1, ADDRESS=latched address; for writes DATA driven with latched WDATA.
REQ-020 STROBE: MEM_RD=1 (read) or MEM_WR=1 (write); ENABLE, ADDRESS, DATA held.
REQ-021 HOLD: strobe, ENABLE, ADDRESS, DATA held; for reads DATA sampled into the granted port's RDATA register at the end of HOLD.
REQ-022 DONE: strobes, ENABLE low, DATA released to high-Z; granted port's ACK=1 for exactly one cycle; next state IDLE.
REQ-023 Valid access latency: REQ sampled at edge N -> ACK high in cycle N+4; ERR access: ACK in cycle N+1, no ENABLE/strobe activity.
REQ-024 MEM_RD and MEM_WR SHALL never be high simultaneously; each rises only from STROBE entry, exactly once per transaction.
REQ-025 DATA SHALL be driven only in SETUP/STROBE/HOLD of a write; high-Z otherwise, including all reads.
REQ-026 Requester SHALL hold REQ and operands until ACK and drop REQ in the cycle after ACK; port inputs changing after grant SHALL be ignored.
REQ-027 RDATA SHALL hold its last value until the next read for that port; ERR clears on the port's next ACK.
REQ-028 Window check: ERR when ADDR < BASE or ADDR >= BASE+DEPTH, computed 14 bits wide to avoid wrap; 13'h1FFF valid, 13'h0FFF invalid.
REQ-029 Non-granted port's ACK/ERR SHALL stay 0; its request waits in IDLE of the following arbitration.

Reset
REQ-030 RST high SHALL force state IDLE, ENABLE/MEM_RD/MEM_WR=0, ADDRESS=0, DATA high-Z, ACK/ERR=0, RDATA=0, last-grant=B (so A wins first tie), on the next edge.
REQ-031 Reset during any transaction SHALL abort it with no ACK issued; strobe drops at that edge.

Structure
REQ-032 Shared package ram_ctrl_pkg SHALL hold the state encoding, BASE and DEPTH defaults.
REQ-033 Round-robin grant SHALL be a sub-module rr_arb2 (inputs req[1:0], update, output grant[1:0], registered last-grant).

Verification
REQ-034 A write 8'h5A to 13'h1004 -> ENABLE cycles N+1..N+3, MEM_WR only N+2..N+3, A_ACK at N+4, A_ERR=0.
REQ-035 A read of 13'h1004 after REQ-034 -> MEM_RD N+2..N+3, A_RDATA=8'h5A with A_ACK at N+4.
REQ-036 A and B request same edge after reset -> A served first, B ACK four cycles after returning to IDLE; repeat tie -> B first.
REQ-037 B read 13'h0FFF -> B_ACK and B_ERR at N+1, no ENABLE/strobe; B read 13'h1FFF -> no error.
REQ-038 RST asserted during STROBE of a write -> next cycle all strobes 0, DATA high-Z, no ACK; later read of that address completes normally.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the dual-port RAM arbiter: state encoding, bus widths
// and the default RAM window.
package ram_ctrl_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;
    localparam int N_PORTS = 2;

    localparam logic [ADDR_W-1:0] BASE_DEFAULT  = 13'h1000;
    localparam int unsigned       DEPTH_DEFAULT = 4096;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Done one bit wider than the address so BASE+DEPTH can reach 2**ADDR_W without wrapping.
    function automatic logic addr_out_of_window(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W:0]   depth
    );
        logic [ADDR_W:0] a_ext;
        logic [ADDR_W:0] lo_ext;
        logic [ADDR_W:0] hi_ext;
        a_ext  = {1'b0, addr};
        lo_ext = {1'b0, base};
        hi_ext = lo_ext + depth;
        return (a_ext < lo_ext) || (a_ext >= hi_ext);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. Bit 0 is port A, bit 1 is port B; on a tie
// the port that did not win the previous arbitration is granted.
module rr_arb2 (
    input  logic       clk,
    input  logic       srst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic last_b_reg;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_b_reg ? 2'b01 : 2'b10;
        end
    end

    // Reset to "B last" so port A wins the first tie.
    always_ff @(posedge clk) begin
        if (srst) begin
            last_b_reg <= 1'b1;
        end else if (update && (grant != 2'b00)) begin
            last_b_reg <= grant[1];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates a CPU port (A) and a DMA port (B) onto an asynchronous byte RAM
// using a SETUP/STROBE/HOLD access sequence; out-of-window addresses complete at once with ERR.
module ram_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE  = BASE_DEFAULT,
    parameter int unsigned       DEPTH = DEPTH_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              A_REQ,
    input  logic              A_WE,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_WDATA,
    output logic [DATA_W-1:0] A_RDATA,
    output logic              A_ACK,
    output logic              A_ERR,
    input  logic              B_REQ,
    input  logic              B_WE,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_WDATA,
    output logic [DATA_W-1:0] B_RDATA,
    output logic              B_ACK,
    output logic              B_ERR,
    inout  wire  [DATA_W-1:0] DATA,
    output logic [ADDR_W-1:0] ADDRESS,
    output logic              ENABLE,
    output logic              MEM_RD,
    output logic              MEM_WR
);

    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_t state_reg;
    state_t state_next;

    logic [N_PORTS-1:0] req_vec;
    logic [N_PORTS-1:0] grant;
    logic               we_in    [N_PORTS];
    logic [ADDR_W-1:0]  addr_in  [N_PORTS];
    logic [DATA_W-1:0]  wdata_in [N_PORTS];

    logic               sel_b;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_err;

    logic [N_PORTS-1:0] gnt_reg;
    logic               we_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [DATA_W-1:0]  wdata_reg;
    logic               err_reg;

    logic               enable;
    logic               mem_rd;
    logic               mem_wr;
    logic               data_oe;

    logic [N_PORTS-1:0] ack;
    logic [N_PORTS-1:0] err;
    logic [DATA_W-1:0]  rdata_reg [N_PORTS];

    assign req_vec     = {B_REQ, A_REQ};
    assign we_in[0]    = A_WE;
    assign we_in[1]    = B_WE;
    assign addr_in[0]  = A_ADDR;
    assign addr_in[1]  = B_ADDR;
    assign wdata_in[0] = A_WDATA;
    assign wdata_in[1] = B_WDATA;

    rr_arb2 u_arb (
        .clk    (CLK),
        .srst   (RST),
        .req    (req_vec),
        .update (state_reg == ST_IDLE),
        .grant  (grant)
    );

    // The grant is one-hot, so bit 1 alone selects which port's operands are latched.
    assign sel_b     = grant[1];
    assign sel_we    = we_in[sel_b];
    assign sel_addr  = addr_in[sel_b];
    assign sel_wdata = wdata_in[sel_b];
    assign sel_err   = addr_out_of_window(sel_addr, BASE, DEPTH_EXT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_IDLE;
            gnt_reg   <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == ST_IDLE) && (grant != '0)) begin
                gnt_reg   <= grant;
                we_reg    <= sel_we;
                addr_reg  <= sel_addr;
                wdata_reg <= sel_wdata;
                err_reg   <= sel_err;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        enable     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        data_oe    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (grant != '0) begin
                    state_next = sel_err ? ST_DONE : ST_SETUP;
                end
            end
            ST_SETUP: begin
                enable     = 1'b1;
                data_oe    = we_reg;
                state_next = ST_STROBE;
            end
            ST_STROBE: begin
                enable     = 1'b1;
                data_oe    = we_reg;
                mem_rd     = ~we_reg;
                mem_wr     = we_reg;
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                enable     = 1'b1;
                data_oe    = we_reg;
                mem_rd     = ~we_reg;
                mem_wr     = we_reg;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign ENABLE  = enable;
    assign MEM_RD  = mem_rd;
    assign MEM_WR  = mem_wr;
    assign ADDRESS = addr_reg;
    assign DATA    = data_oe ? wdata_reg : {DATA_W{1'bz}};

    genvar gi;
    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_port
            assign ack[gi] = (state_reg == ST_DONE) && gnt_reg[gi];
            assign err[gi] = ack[gi] && err_reg;

            // Read data is captured on the edge that leaves HOLD, while the RAM still drives the bus.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    rdata_reg[gi] <= '0;
                end else if ((state_reg == ST_HOLD) && !we_reg && gnt_reg[gi]) begin
                    rdata_reg[gi] <= DATA;
                end
            end
        end
    endgenerate

    assign A_ACK   = ack[0];
    assign B_ACK   = ack[1];
    assign A_ERR   = err[0];
    assign B_ERR   = err[1];
    assign A_RDATA = rdata_reg[0];
    assign B_RDATA = rdata_reg[1];

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: port drivers queue the expected completion,
// a monitor pops and checks on every ACK and polices the RAM strobes.
module tb_ram_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        A_REQ, A_WE, B_REQ, B_WE;
    logic [12:0] A_ADDR, B_ADDR;
    logic [7:0]  A_WDATA, B_WDATA;
    logic [7:0]  A_RDATA, B_RDATA;
    logic        A_ACK, A_ERR, B_ACK, B_ERR;
    wire  [7:0]  DATA;
    logic [12:0] ADDRESS;
    logic        ENABLE, MEM_RD, MEM_WR;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         start;
        logic [7:0] rdata;
        bit         chk_rdata;
        bit         err;
        int         lat;
        int         en;
        int         rd;
        int         wr;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    ram_arbiter dut (
        .CLK(CLK), .RST(RST),
        .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
        .A_RDATA(A_RDATA), .A_ACK(A_ACK), .A_ERR(A_ERR),
        .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
        .B_RDATA(B_RDATA), .B_ACK(B_ACK), .B_ERR(B_ERR),
        .DATA(DATA), .ADDRESS(ADDRESS), .ENABLE(ENABLE),
        .MEM_RD(MEM_RD), .MEM_WR(MEM_WR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Asynchronous RAM: write on the rising MEM_WR edge, drive the bus while read-strobed.
    logic [7:0] mem [0:8191];
    always @(posedge MEM_WR) if (ENABLE) mem[ADDRESS] <= DATA;
    assign DATA = (ENABLE && MEM_RD) ? mem[ADDRESS] : 8'hzz;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic monitor();
        int en_c = 0;
        int rd_c = 0;
        int wr_c = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                en_c = 0; rd_c = 0; wr_c = 0;
            end else begin
                if (MEM_RD && MEM_WR) check("rd_wr_overlap", 1, 0);
                if (A_ACK && B_ACK)   check("dual_ack", 1, 0);
                if (A_ERR && !A_ACK)  check("a_err_without_ack", 1, 0);
                if (B_ERR && !B_ACK)  check("b_err_without_ack", 1, 0);
                if (ENABLE) en_c++;
                if (MEM_RD) rd_c++;
                if (MEM_WR) wr_c++;
                for (int p = 0; p < 2; p++) begin
                    logic ack;
                    ack = (p == 0) ? A_ACK : B_ACK;
                    if (ack) begin
                        exp_t e;
                        bit   have;
                        have = 1'b0;
                        if (p == 0 && qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
                        if (p == 1 && qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
                        if (!have) begin
                            check(p == 0 ? "a_unexpected_ack" : "b_unexpected_ack", 1, 0);
                        end else begin
                            check(p == 0 ? "a_latency" : "b_latency", cyc - e.start, e.lat);
                            check(p == 0 ? "a_err" : "b_err", p == 0 ? A_ERR : B_ERR, e.err);
                            if (e.chk_rdata)
                                check(p == 0 ? "a_rdata" : "b_rdata", p == 0 ? A_RDATA : B_RDATA, e.rdata);
                            check("enable_cycles", en_c, e.en);
                            check("mem_rd_cycles", rd_c, e.rd);
                            check("mem_wr_cycles", wr_c, e.wr);
                            $display("ACK port=%s cyc=%0d lat=%0d err=%0b rdata=%02h",
                                     p == 0 ? "A" : "B", cyc, cyc - e.start,
                                     p == 0 ? A_ERR : B_ERR, p == 0 ? A_RDATA : B_RDATA);
                        end
                        en_c = 0; rd_c = 0; wr_c = 0;
                    end
                end
            end
        end
    endtask

    task automatic txn(input bit p, input bit we, input logic [12:0] addr, input logic [7:0] wd,
                       input logic [7:0] rd, input bit chk, input bit err, input int lat,
                       input bit scramble);
        exp_t e;
        int   n;
        bit   acked;
        @(negedge CLK);
        if (!p) begin A_WE = we; A_ADDR = addr; A_WDATA = wd; A_REQ = 1'b1; end
        else    begin B_WE = we; B_ADDR = addr; B_WDATA = wd; B_REQ = 1'b1; end
        e.start = cyc; e.rdata = rd; e.chk_rdata = chk; e.err = err; e.lat = lat;
        e.en = err ? 0 : 3;
        e.rd = (err || we) ? 0 : 2;
        e.wr = (!err && we) ? 2 : 0;
        if (!p) qa.push_back(e); else qb.push_back(e);
        n = 0;
        acked = 1'b0;
        while (!acked && n < 40) begin
            @(negedge CLK);
            n++;
            if (scramble && n == 2) begin
                if (!p) begin A_ADDR = 13'h1234; A_WDATA = 8'hFF; end
                else    begin B_ADDR = 13'h1234; B_WDATA = 8'hFF; end
            end
            acked = !p ? A_ACK : B_ACK;
        end
        if (!acked) check(p ? "b_ack_timeout" : "a_ack_timeout", 0, 1);
        if (!p) A_REQ = 1'b0; else B_REQ = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; A_REQ = 1'b0; B_REQ = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        int n;
        RST = 1'b1;
        A_REQ = 1'b0; A_WE = 1'b0; A_ADDR = '0; A_WDATA = '0;
        B_REQ = 1'b0; B_WE = 1'b0; B_ADDR = '0; B_WDATA = '0;
        fork monitor(); join_none
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        check("rst_enable", ENABLE, 0);
        check("rst_mem_rd", MEM_RD, 0);
        check("rst_mem_wr", MEM_WR, 0);
        check("rst_address", ADDRESS, 0);
        check("rst_a_ack", A_ACK, 0);
        check("rst_b_ack", B_ACK, 0);
        check("rst_a_err", A_ERR, 0);
        check("rst_b_err", B_ERR, 0);
        check("rst_a_rdata", A_RDATA, 0);
        check("rst_b_rdata", B_RDATA, 0);

        // Basic write/read, with operands changed after grant on the writes.
        txn(0, 1, 13'h1004, 8'h5A, 8'h00, 0, 0, 4, 1);
        txn(0, 0, 13'h1004, 8'h00, 8'h5A, 1, 0, 4, 0);
        txn(1, 1, 13'h1FFF, 8'hA7, 8'h00, 0, 0, 4, 1);
        txn(1, 0, 13'h0FFF, 8'h00, 8'h00, 1, 1, 1, 0);
        txn(1, 0, 13'h1FFF, 8'h00, 8'hA7, 1, 0, 4, 0);
        txn(0, 0, 13'h0000, 8'h00, 8'h5A, 1, 1, 1, 0);
        txn(0, 1, 13'h1000, 8'h11, 8'h00, 0, 0, 4, 0);
        txn(0, 0, 13'h1000, 8'h00, 8'h11, 1, 0, 4, 0);

        // Tie after reset: A first, B follows four cycles after IDLE.
        do_reset();
        fork
            txn(0, 0, 13'h1004, 8'h00, 8'h5A, 1, 0, 4, 0);
            txn(1, 0, 13'h1FFF, 8'h00, 8'hA7, 1, 0, 9, 0);
        join
        // A wins alone, so the next tie goes to B.
        txn(0, 1, 13'h1010, 8'h3C, 8'h00, 0, 0, 4, 0);
        fork
            txn(0, 0, 13'h1010, 8'h00, 8'h3C, 1, 0, 9, 0);
            txn(1, 0, 13'h1004, 8'h00, 8'h5A, 1, 0, 4, 0);
        join

        // Reset in the STROBE cycle of a write aborts it without an ACK.
        @(negedge CLK);
        A_WE = 1'b1; A_ADDR = 13'h1008; A_WDATA = 8'hC3; A_REQ = 1'b1;
        n = 0;
        while (!MEM_WR && n < 10) begin @(negedge CLK); n++; end
        check("abort_reached_strobe", MEM_WR, 1);
        RST = 1'b1; A_REQ = 1'b0;
        @(negedge CLK);
        check("abort_enable", ENABLE, 0);
        check("abort_mem_wr", MEM_WR, 0);
        check("abort_mem_rd", MEM_RD, 0);
        check("abort_a_ack", A_ACK, 0);
        check("abort_address", ADDRESS, 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            check("abort_no_late_ack", A_ACK, 0);
        end
        txn(0, 0, 13'h1008, 8'h00, 8'hC3, 1, 0, 4, 0);

        repeat (3) @(negedge CLK);
        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
